// File: rtl/ft_de_btbn.sv
// Fetch->decode pipeline register with a small fully-associative branch target buffer.
// Entries capture {pc,instr} of the first instruction issued after a taken decode branch.
module ft_de_btbn #(
    parameter int BTB_DEPTH = 4,
    parameter int BTB_DLY   = 10
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        fet_flush,
    input  logic        branch_predict_err,
    input  logic        de_stall,
    input  logic        ext_stall,
    input  logic        cross_bd_ff,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] rv32_instr_todec,
    input  logic [15:0] rv16_instr_todec,
    input  logic        fe2de_rv16,
    input  logic        predict_bxxtaken,
    input  logic        de2fe_branch,
    input  logic        de2ex_inst_valid,
    input  logic        btb_inval,
    input  logic [31:0] btb_lookup_pc,
    output logic [31:0] fe2de_pc_ffout,
    output logic [31:0] fe2de_instr_ffout,
    output logic        fe2de_rv16_ffout,
    output logic        fe2de_predict_bxxtaken_ffout,
    output logic        fet_stall,
    output logic        btb_valid,
    output logic        btb_hit,
    output logic [31:0] btb_hit_instr
);
    localparam int PW = $clog2(BTB_DEPTH);

    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic                 r_rv16;
    logic                 r_pred;
    logic [15:0]          r_rv16_instr;
    logic [3:0]           r_cnt;
    logic                 r_arm;
    logic [PW-1:0]        r_victim;
    logic [BTB_DEPTH-1:0] r_vld;
    logic [31:0]          r_ent_pc    [BTB_DEPTH];
    logic [31:0]          r_ent_instr [BTB_DEPTH];

    logic                 w_flush;
    logic                 w_wr;
    logic [31:0]          w_wdata;
    logic                 w_upd_hit;
    logic [PW-1:0]        w_upd_idx;
    logic                 w_lk_any;
    logic [31:0]          w_lk_instr;

    assign w_flush   = fet_flush | branch_predict_err;
    assign fet_stall = de_stall | ext_stall;
    assign w_wr      = r_arm & de2ex_inst_valid;
    assign w_wdata   = r_rv16 ? {16'h0000, r_rv16_instr} : r_instr;

    always_comb begin
        w_upd_hit  = 1'b0;
        w_upd_idx  = '0;
        w_lk_any   = 1'b0;
        w_lk_instr = '0;
        for (int i = 0; i < BTB_DEPTH; i++) begin
            if (r_vld[i] && r_ent_pc[i] == r_pc) begin
                w_upd_hit = 1'b1;
                w_upd_idx = PW'(i);
            end
            // At most one valid entry per pc, so OR-combining is a clean mux.
            if (r_vld[i] && r_ent_pc[i] == btb_lookup_pc) begin
                w_lk_any   = 1'b1;
                w_lk_instr = w_lk_instr | r_ent_instr[i];
            end
        end
    end

    assign btb_valid     = (r_cnt == 4'(BTB_DLY));
    assign btb_hit       = btb_valid & w_lk_any;
    assign btb_hit_instr = btb_hit ? w_lk_instr : 32'h0;

    assign fe2de_pc_ffout               = r_pc;
    assign fe2de_instr_ffout            = r_instr;
    assign fe2de_rv16_ffout             = r_rv16;
    assign fe2de_predict_bxxtaken_ffout = r_pred;

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_pc         <= '0;
            r_instr      <= '0;
            r_rv16       <= 1'b0;
            r_pred       <= 1'b0;
            r_rv16_instr <= '0;
            r_cnt        <= '0;
            r_arm        <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rv16 <= 1'b0;
                r_pred <= 1'b0;
            end else if (!de_stall) begin
                r_rv16 <= fe2de_rv16;
                r_pred <= predict_bxxtaken;
            end
            if (w_flush || (cross_bd_ff && !de_stall))
                r_instr <= '0;
            else if (!fet_stall)
                r_instr <= rv32_instr_todec;
            if (!fet_stall)
                r_pc <= fetch_pc;
            r_rv16_instr <= rv16_instr_todec;
            if (r_cnt != 4'(BTB_DLY))
                r_cnt <= r_cnt + 4'd1;
            if (de2fe_branch)
                r_arm <= 1'b1;
            else if (w_wr)
                r_arm <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_vld    <= '0;
            r_victim <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_ent_pc[i]    <= '0;
                r_ent_instr[i] <= '0;
            end
        end else if (btb_inval) begin
            r_vld    <= '0;
            r_victim <= '0;
        end else if (w_wr) begin
            // Existing pc is refreshed in place so the victim pointer only moves on allocation.
            if (w_upd_hit) begin
                r_ent_instr[w_upd_idx] <= w_wdata;
            end else begin
                r_ent_pc[r_victim]    <= r_pc;
                r_ent_instr[r_victim] <= w_wdata;
                r_vld[r_victim]       <= 1'b1;
                r_victim              <= r_victim + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ft_de_btbn.sv
// Directed plus randomized bench for ft_de_btbn against a FIFO-replacement reference model.
module tb_ft_de_btbn;
    localparam int DEPTH = 4;
    localparam int DLY   = 10;

    logic        clk;
    logic        cpurst;
    logic        fet_flush, branch_predict_err, de_stall, ext_stall, cross_bd_ff;
    logic [31:0] fetch_pc, rv32_instr_todec;
    logic [15:0] rv16_instr_todec;
    logic        fe2de_rv16, predict_bxxtaken, de2fe_branch, de2ex_inst_valid, btb_inval;
    logic [31:0] btb_lookup_pc;
    logic [31:0] fe2de_pc_ffout, fe2de_instr_ffout;
    logic        fe2de_rv16_ffout, fe2de_predict_bxxtaken_ffout, fet_stall;
    logic        btb_valid, btb_hit;
    logic [31:0] btb_hit_instr;

    ft_de_btbn #(.BTB_DEPTH(DEPTH), .BTB_DLY(DLY)) dut (
        .clk(clk), .cpurst(cpurst), .fet_flush(fet_flush),
        .branch_predict_err(branch_predict_err), .de_stall(de_stall), .ext_stall(ext_stall),
        .cross_bd_ff(cross_bd_ff), .fetch_pc(fetch_pc), .rv32_instr_todec(rv32_instr_todec),
        .rv16_instr_todec(rv16_instr_todec), .fe2de_rv16(fe2de_rv16),
        .predict_bxxtaken(predict_bxxtaken), .de2fe_branch(de2fe_branch),
        .de2ex_inst_valid(de2ex_inst_valid), .btb_inval(btb_inval), .btb_lookup_pc(btb_lookup_pc),
        .fe2de_pc_ffout(fe2de_pc_ffout), .fe2de_instr_ffout(fe2de_instr_ffout),
        .fe2de_rv16_ffout(fe2de_rv16_ffout),
        .fe2de_predict_bxxtaken_ffout(fe2de_predict_bxxtaken_ffout),
        .fet_stall(fet_stall), .btb_valid(btb_valid), .btb_hit(btb_hit),
        .btb_hit_instr(btb_hit_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference: entries kept oldest-first; allocation into a full table drops the oldest.
    ent_t        q[$];
    logic [31:0] m_pc, m_instr;
    logic        m_rv16, m_pred, m_arm;
    logic [15:0] m_copy;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_pc = 0; m_instr = 0; m_rv16 = 0; m_pred = 0; m_arm = 0; m_copy = 0; m_cnt = 0;
    endtask

    task automatic m_write(input logic [31:0] pc, input logic [31:0] d);
        ent_t e;
        foreach (q[i]) begin
            if (q[i].pc == pc) begin
                q[i].instr = d;
                return;
            end
        end
        if (q.size() == DEPTH) void'(q.pop_front());
        e.pc = pc;
        e.instr = d;
        q.push_back(e);
    endtask

    task automatic m_lookup(input logic [31:0] a, output logic h, output logic [31:0] d);
        h = 0;
        d = 0;
        if (m_cnt >= DLY) begin
            foreach (q[i]) begin
                if (q[i].pc == a) begin
                    h = 1;
                    d = q[i].instr;
                end
            end
        end
    endtask

    task automatic m_edge();
        logic        flush, fs, wr;
        logic [31:0] wd;
        if (cpurst) begin
            m_reset();
            return;
        end
        flush = fet_flush | branch_predict_err;
        fs    = de_stall | ext_stall;
        wr    = m_arm & de2ex_inst_valid;
        wd    = m_rv16 ? {16'h0000, m_copy} : m_instr;
        if (btb_inval) q.delete();
        else if (wr) m_write(m_pc, wd);
        if (de2fe_branch) m_arm = 1;
        else if (wr) m_arm = 0;
        if (flush || (cross_bd_ff && !de_stall)) m_instr = 0;
        else if (!fs) m_instr = rv32_instr_todec;
        if (flush) begin
            m_rv16 = 0;
            m_pred = 0;
        end else if (!de_stall) begin
            m_rv16 = fe2de_rv16;
            m_pred = predict_bxxtaken;
        end
        if (!fs) m_pc = fetch_pc;
        m_copy = rv16_instr_todec;
        if (m_cnt < DLY) m_cnt++;
    endtask

    // Check every output against the model, then advance one clock.
    task automatic cyc();
        logic        eh;
        logic [31:0] ed;
        if (cpurst) m_reset();
        #1;
        m_lookup(btb_lookup_pc, eh, ed);
        chk("pc",        fe2de_pc_ffout, m_pc);
        chk("instr",     fe2de_instr_ffout, m_instr);
        chk("rv16",      {31'd0, fe2de_rv16_ffout}, {31'd0, m_rv16});
        chk("pred",      {31'd0, fe2de_predict_bxxtaken_ffout}, {31'd0, m_pred});
        chk("fet_stall", {31'd0, fet_stall}, {31'd0, de_stall | ext_stall});
        chk("btb_valid", {31'd0, btb_valid}, (m_cnt >= DLY) ? 32'd1 : 32'd0);
        chk("btb_hit",   {31'd0, btb_hit}, {31'd0, eh});
        chk("hit_instr", btb_hit_instr, ed);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [31:0] i32,
                         input logic is16, input logic [15:0] i16);
        de2fe_branch = 1; fetch_pc = pc; rv32_instr_todec = i32;
        fe2de_rv16 = is16; rv16_instr_todec = i16;
        cyc();
        de2fe_branch = 0; de2ex_inst_valid = 1;
        cyc();
        de2ex_inst_valid = 0;
    endtask

    task automatic probe(input string tag, input logic [31:0] a,
                         input logic eh, input logic [31:0] ed);
        btb_lookup_pc = a;
        #1;
        chk({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, eh});
        chk({tag, "_data"}, btb_hit_instr, ed);
        cyc();
    endtask

    initial begin
        logic [31:0] pcs [9];
        cpurst = 1; fet_flush = 0; branch_predict_err = 0; de_stall = 0; ext_stall = 0;
        cross_bd_ff = 0; fetch_pc = 0; rv32_instr_todec = 0; rv16_instr_todec = 0;
        fe2de_rv16 = 0; predict_bxxtaken = 0; de2fe_branch = 0; de2ex_inst_valid = 0;
        btb_inval = 0; btb_lookup_pc = 0;
        m_reset();
        cyc();
        cyc();
        chk("rst_instr", fe2de_instr_ffout, 32'h0);

        // Warm-up: no hits for 9 cycles, valid on the 10th.
        cpurst = 0;
        btb_lookup_pc = 32'h100;
        for (int i = 0; i < 9; i++) cyc();
        chk("warm9_valid", {31'd0, btb_valid}, 32'd0);
        cyc();
        chk("warm10_valid", {31'd0, btb_valid}, 32'd1);
        chk("warm10_hit", {31'd0, btb_hit}, 32'd0);

        alloc(32'h100, 32'h00A00093, 0, 16'h0);
        probe("first", 32'h100, 1, 32'h00A00093);

        alloc(32'h110, 32'h11, 0, 16'h0);
        alloc(32'h120, 32'h12, 0, 16'h0);
        alloc(32'h130, 32'h13, 0, 16'h0);
        alloc(32'h140, 32'h14, 0, 16'h0);
        probe("evict100", 32'h100, 0, 32'h0);
        probe("keep110", 32'h110, 1, 32'h11);
        probe("keep140", 32'h140, 1, 32'h14);

        alloc(32'h120, 32'h1234, 0, 16'h0);
        probe("upd120", 32'h120, 1, 32'h1234);
        probe("upd110", 32'h110, 1, 32'h11);
        alloc(32'h150, 32'h15, 0, 16'h0);
        probe("vict110", 32'h110, 0, 32'h0);
        probe("vict120", 32'h120, 1, 32'h1234);

        // Invalidate wins over a same-cycle write.
        de2fe_branch = 1; fetch_pc = 32'h160; rv32_instr_todec = 32'h16; fe2de_rv16 = 0;
        cyc();
        de2fe_branch = 0; de2ex_inst_valid = 1; btb_inval = 1;
        cyc();
        de2ex_inst_valid = 0; btb_inval = 0;
        probe("inv160", 32'h160, 0, 32'h0);
        probe("inv150", 32'h150, 0, 32'h0);

        // Flush while decode stalled.
        fetch_pc = 32'h300; rv32_instr_todec = 32'hDEADBEEF; fe2de_rv16 = 1; predict_bxxtaken = 1;
        cyc();
        fet_flush = 1; de_stall = 1; fetch_pc = 32'h304;
        cyc();
        chk("flush_instr", fe2de_instr_ffout, 32'h0);
        chk("flush_rv16", {31'd0, fe2de_rv16_ffout}, 32'd0);
        chk("flush_pred", {31'd0, fe2de_predict_bxxtaken_ffout}, 32'd0);
        chk("flush_pc", fe2de_pc_ffout, 32'h300);
        fet_flush = 0; de_stall = 0; predict_bxxtaken = 0;

        alloc(32'h200, 32'hCAFEF00D, 1, 16'h4501);
        probe("rv16", 32'h200, 1, 32'h00004501);

        // Randomized traffic over a small pc set so hits, updates and evictions recur.
        pcs = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h140, 32'h150, 32'h160, 32'h170, 32'h200};
        for (int n = 0; n < 600; n++) begin
            cpurst             = ($urandom_range(0, 199) == 0);
            fet_flush          = ($urandom_range(0, 19) == 0);
            branch_predict_err = ($urandom_range(0, 19) == 0);
            de_stall           = ($urandom_range(0, 5) == 0);
            ext_stall          = ($urandom_range(0, 5) == 0);
            cross_bd_ff        = ($urandom_range(0, 9) == 0);
            fetch_pc           = pcs[$urandom_range(0, 8)];
            rv32_instr_todec   = $urandom;
            rv16_instr_todec   = 16'($urandom);
            fe2de_rv16         = $urandom_range(0, 1) != 0;
            predict_bxxtaken   = $urandom_range(0, 1) != 0;
            de2fe_branch       = ($urandom_range(0, 3) == 0);
            de2ex_inst_valid   = $urandom_range(0, 1) != 0;
            btb_inval          = ($urandom_range(0, 59) == 0);
            btb_lookup_pc      = pcs[$urandom_range(0, 8)];
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
